// File: rtl/pipe_stage_skid_pkg.sv
// Shared constants for the pipeline-stage skid register and its helpers.
package pipe_stage_skid_pkg;

  localparam int XLEN_DEF     = 64;
  localparam int INST_LEN_DEF = 32;

  // pc value presented while the stage holds a bubble
  localparam logic [63:0] PIPE_BUBBLE_PC = 64'h0;

  // width of the packed {pc, instr, side} payload vector
  function automatic int payload_w(input int xlen, input int inst_len, input int side_w);
    return xlen + inst_len + side_w;
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter for performance-debug events; never wraps.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // count events, sticking at all-ones; only reset clears
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a 2-entry skid buffer. M drives the
// outputs, S catches the one entry that can arrive while M is stalled, so
// in_ready is a pure register view and never sees out_ready combinationally.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int XLEN        = XLEN_DEF,
  parameter int INST_LEN    = INST_LEN_DEF,
  parameter int SIDE_W      = 8,
  parameter int CNT_W       = 16,
  parameter bit ZERO_BUBBLE = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     in_pc,
  input  logic [INST_LEN-1:0] in_instr,
  input  logic [SIDE_W-1:0]   in_side,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_pc,
  output logic [INST_LEN-1:0] out_instr,
  output logic [SIDE_W-1:0]   out_side,
  output logic [1:0]          occupancy,
  output logic [CNT_W-1:0]    stall_cnt
);

  localparam int PAYLOAD_W = payload_w(XLEN, INST_LEN, SIDE_W);

  logic                 m_valid;
  logic                 s_valid;
  logic [PAYLOAD_W-1:0] m_data;
  logic [PAYLOAD_W-1:0] s_data;
  logic [PAYLOAD_W-1:0] in_data;
  logic [PAYLOAD_W-1:0] out_data;
  logic                 in_fire;
  logic                 out_fire;

  assign in_data  = {in_pc, in_instr, in_side};
  assign in_ready = ~s_valid;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = m_valid & out_ready;

  // main/skid registers; S is always the younger entry
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_data  <= '0;
      s_data  <= '0;
    end else if (!m_valid) begin
      if (in_fire) begin
        m_valid <= 1'b1;
        m_data  <= in_data;
      end
    end else if (out_fire) begin
      if (s_valid) begin
        // in_ready was low, so nothing new can arrive this cycle
        m_data  <= s_data;
        s_valid <= 1'b0;
        s_data  <= '0;
      end else if (in_fire) begin
        m_data <= in_data;
      end else begin
        // keep m_data so ZERO_BUBBLE=0 can show the last entry
        m_valid <= 1'b0;
      end
    end else if (in_fire) begin
      s_valid <= 1'b1;
      s_data  <= in_data;
    end
  end

  // present M, or a zeroed bubble when configured and M is empty
  always_comb begin
    out_data = m_data;
    if (ZERO_BUBBLE && !m_valid) begin
      out_data = {XLEN'(PIPE_BUBBLE_PC), {INST_LEN{1'b0}}, {SIDE_W{1'b0}}};
    end
  end

  assign out_valid = m_valid;
  assign out_pc    = out_data[PAYLOAD_W-1 -: XLEN];
  assign out_instr = out_data[SIDE_W +: INST_LEN];
  assign out_side  = out_data[SIDE_W-1:0];
  assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (m_valid & ~out_ready),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and randomised checks of pipe_stage_skid. Two instances share
// stimulus: dut0 uses defaults, dut1 has CNT_W=4 and ZERO_BUBBLE=0.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [63:0] in_pc;
  logic [31:0] in_instr;
  logic [7:0]  in_side;

  logic        in_ready_0, out_valid_0;
  logic [63:0] out_pc_0;
  logic [31:0] out_instr_0;
  logic [7:0]  out_side_0;
  logic [1:0]  occ_0;
  logic [15:0] stall_0;

  logic        in_ready_1, out_valid_1;
  logic [63:0] out_pc_1;
  logic [31:0] out_instr_1;
  logic [7:0]  out_side_1;
  logic [1:0]  occ_1;
  logic [3:0]  stall_1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_skid dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_0),
    .in_pc(in_pc), .in_instr(in_instr), .in_side(in_side),
    .out_valid(out_valid_0), .out_ready(out_ready),
    .out_pc(out_pc_0), .out_instr(out_instr_0), .out_side(out_side_0),
    .occupancy(occ_0), .stall_cnt(stall_0)
  );

  pipe_stage_skid #(.CNT_W(4), .ZERO_BUBBLE(1'b0)) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_1),
    .in_pc(in_pc), .in_instr(in_instr), .in_side(in_side),
    .out_valid(out_valid_1), .out_ready(out_ready),
    .out_pc(out_pc_1), .out_instr(out_instr_1), .out_side(out_side_1),
    .occupancy(occ_1), .stall_cnt(stall_1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] pc);
    in_valid = v;
    in_pc    = pc;
    in_instr = pc[31:0] ^ 32'h0000_0013;
    in_side  = pc[9:2];
  endtask

  function automatic logic [63:0] rnd_pc(input int s);
    return 64'h1000 + 64'(s) * 4;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          seq;
    int          q[$];
    logic [63:0] last_pc;
    int          exp_front;

    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 64'h0);
    step(); step();
    rst = 1'b0;

    // reset state
    chk("rst_in_ready",  64'(in_ready_0), 64'd1);
    chk("rst_out_valid", 64'(out_valid_0), 64'd0);
    chk("rst_occ",       64'(occ_0), 64'd0);
    chk("rst_out_pc",    out_pc_0, 64'd0);
    chk("rst_stall",     64'(stall_0), 64'd0);

    // streaming, out_ready held high
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'h8000_0000 + 64'(i) * 4);
      step();
      chk("str_valid",    64'(out_valid_0), 64'd1);
      chk("str_pc",       out_pc_0, 64'h8000_0000 + 64'(i) * 4);
      chk("str_instr",    64'(out_instr_0), 64'((32'h8000_0000 + 32'(i) * 4) ^ 32'h13));
      chk("str_in_ready", 64'(in_ready_0), 64'd1);
      chk("str_occ",      64'(occ_0), 64'd1);
    end
    drive(1'b0, 64'h0);
    step();
    chk("str_drain_valid", 64'(out_valid_0), 64'd0);
    chk("str_drain_pc0",   out_pc_0, 64'd0);
    chk("str_hold_pc1",    out_pc_1, 64'h8000_0008);

    // back-pressure fill with two entries
    out_ready = 1'b0;
    drive(1'b1, 64'h100); step();
    drive(1'b1, 64'h104); step();
    drive(1'b0, 64'h0);
    chk("bp_occ",      64'(occ_0), 64'd2);
    chk("bp_in_ready", 64'(in_ready_0), 64'd0);
    chk("bp_out_pc",   out_pc_0, 64'h100);
    for (int i = 0; i < 4; i++) step();
    chk("bp_stall",    64'(stall_0), 64'd5);
    out_ready = 1'b1;
    step();
    chk("bp_rel_pc1",  out_pc_0, 64'h104);
    chk("bp_rel_occ",  64'(occ_0), 64'd1);
    chk("bp_rel_rdy",  64'(in_ready_0), 64'd1);
    step();
    chk("bp_rel_empty", 64'(out_valid_0), 64'd0);
    chk("bp_hold_pc1",  out_pc_1, 64'h104);
    chk("bp_stall_keep", 64'(stall_0), 64'd5);

    // flush with two held entries plus a waiting input
    out_ready = 1'b0;
    drive(1'b1, 64'h300); step();
    drive(1'b1, 64'h304); step();
    drive(1'b1, 64'h200); flush = 1'b1; step();
    flush = 1'b0; drive(1'b0, 64'h0);
    chk("fl_valid", 64'(out_valid_0), 64'd0);
    chk("fl_occ",   64'(occ_0), 64'd0);
    chk("fl_pc",    out_pc_0, 64'd0);
    chk("fl_instr", 64'(out_instr_0), 64'd0);
    chk("fl_pc1",   out_pc_1, 64'd0);
    chk("fl_stall", 64'(stall_0), 64'd7);
    step();
    chk("fl_no_200", 64'(out_valid_0), 64'd0);

    // flush while in_ready=1 drops the incoming entry
    drive(1'b1, 64'h400); step();
    drive(1'b1, 64'h200); flush = 1'b1; step();
    flush = 1'b0; drive(1'b0, 64'h0);
    chk("fl2_valid", 64'(out_valid_0), 64'd0);
    chk("fl2_occ",   64'(occ_0), 64'd0);
    step();
    chk("fl2_no_200", 64'(out_valid_0), 64'd0);
    chk("fl2_stall",  64'(stall_0), 64'd8);

    // reset mid-operation with two held entries
    drive(1'b1, 64'h500); step();
    drive(1'b1, 64'h504); step();
    drive(1'b0, 64'h0);
    chk("mr_occ",   64'(occ_0), 64'd2);
    chk("mr_stall", 64'(stall_0), 64'd9);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mr_valid", 64'(out_valid_0), 64'd0);
    chk("mr_occ0",  64'(occ_0), 64'd0);
    chk("mr_rdy",   64'(in_ready_0), 64'd1);
    chk("mr_pc",    out_pc_0, 64'd0);
    chk("mr_pc1",   out_pc_1, 64'd0);
    chk("mr_stall0", 64'(stall_0), 64'd0);
    chk("mr_stall1", 64'(stall_1), 64'd0);

    // saturation of the 4-bit counter
    drive(1'b1, 64'h600); step();
    drive(1'b0, 64'h0);
    for (int i = 0; i < 20; i++) step();
    chk("sat_c4",  64'(stall_1), 64'd15);
    chk("sat_c16", 64'(stall_0), 64'd20);
    for (int i = 0; i < 3; i++) step();
    chk("sat_c4_hold", 64'(stall_1), 64'd15);
    chk("sat_c16_run", 64'(stall_0), 64'd23);

    // random traffic against a queue model
    rst = 1'b1; step(); rst = 1'b0;
    seq = 0;
    last_pc = 64'h0;
    for (int c = 0; c < 10000; c++) begin
      drive(1'($urandom_range(0, 1)), rnd_pc(seq));
      out_ready = ($urandom_range(0, 9) < 6);
      chk("rnd_s_imp_m", 64'(!dut0.s_valid || dut0.m_valid), 64'd1);
      chk("rnd_occ", 64'(occ_0), 64'(q.size()));
      if (out_valid_0) begin
        exp_front = (q.size() > 0) ? q[0] : -1;
        chk("rnd_pc",    out_pc_0, rnd_pc(exp_front));
        chk("rnd_instr", 64'(out_instr_0), 64'(rnd_pc(exp_front) ^ 64'h13) & 64'hFFFF_FFFF);
        chk("rnd_pc1",   out_pc_1, rnd_pc(exp_front));
      end else begin
        chk("rnd_bub0", out_pc_0, 64'd0);
        chk("rnd_bub1", out_pc_1, last_pc);
      end
      if (out_valid_0 && out_ready && q.size() > 0) begin
        last_pc = rnd_pc(q[0]);
        void'(q.pop_front());
      end
      if (in_valid && in_ready_0) begin
        q.push_back(seq);
        seq++;
      end
      step();
    end
    drive(1'b0, 64'h0);
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (out_valid_0 && q.size() > 0) begin
        chk("drain_pc", out_pc_0, rnd_pc(q[0]));
        void'(q.pop_front());
      end
      step();
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
    chk("drain_valid", 64'(out_valid_0), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised inter-stage pipeline register for the pipelined core. It generalises the fixed stall/flush IF/ID register into a valid/ready handshake stage with a 2-entry skid buffer, which breaks the combinational ready path between stages. The payload is pc plus instruction plus a configurable sideband. It sits between any two pipeline stages (IF/ID, ID/EX, ...). It also provides a saturating back-pressure counter for performance debug.

Parameters:
XLEN, 64, pc width
INST_LEN, 32, instruction width
SIDE_W, 8, sideband payload width (decoded flags, exception bits); must be >= 1
CNT_W, 16, stall counter width
ZERO_BUBBLE, 1, 1: out_pc/out_instr/out_side forced to 0 while out_valid=0; 0: hold last main-register contents

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  kill all held and incoming entries this cycle
in_valid  in  1  upstream has an entry
in_ready  out  1  stage can accept; registered (no comb path from out_ready)
in_pc  in  XLEN  upstream pc
in_instr  in  INST_LEN  upstream instruction
in_side  in  SIDE_W  upstream sideband
out_valid  out  1  main register holds an entry
out_ready  in  1  downstream accepts
out_pc  out  XLEN  main-register pc
out_instr  out  INST_LEN  main-register instruction
out_side  out  SIDE_W  main-register sideband
occupancy  out  2  entries held: 0, 1 or 2
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Storage: main register (M) drives the outputs; skid register (S) holds overflow. FIFO order: S is always younger than M.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = ~S.valid. It is a register bit, so it depends only on state.
- Reset (rst=1 at an edge) has highest priority. M.valid=S.valid=0, all payload=0, stall_cnt=0. After reset: in_ready=1, out_valid=0, occupancy=0, outputs 0.
- Flush (rst=0, flush=1):
  - M.valid=S.valid=0 and payloads zeroed (zero, not NOP, for simulation readability).
  - An in_fire in the same cycle is dropped.
  - out_fire in that cycle is still seen downstream; flush only affects next-state.
  - stall_cnt is not cleared.
- Normal next-state (rst=0, flush=0):
  - M empty: if in_fire, M<=in. S is empty by invariant.
  - M full & out_fire & S full: M<=S, S empty. in_ready was 0, so there is no in_fire.
  - M full & out_fire & S empty: M<=in if in_fire, else M empty.
  - M full & ~out_fire: if in_fire, S<=in (only possible while S empty); M holds.
- Invariant: S.valid implies M.valid. The verifier asserts this.
- Latency: 1 cycle from in_fire to out_valid when empty. Throughput 1 entry/cycle with out_ready held high.
- No entry is lost or duplicated under any in_valid/out_ready pattern unless flush or rst is asserted.
- Payload outputs:
  - ZERO_BUBBLE=1: outputs = M payload when M.valid, else 0.
  - ZERO_BUBBLE=0: outputs = M payload always.
- occupancy = M.valid + S.valid, registered view of the current state.
- stall_cnt: increments each cycle with out_valid & ~out_ready. It saturates at all-ones and never wraps. Only rst clears it.

Decomposition:
- Shared defines header (existing): XLEN and inst_len defaults feed the parameters. Add the constant PIPE_BUBBLE_PC = 0 for a zeroed bubble.
- Add a packed payload width constant: PAYLOAD_W = XLEN+INST_LEN+SIDE_W. Internally concatenate the payload into one vector.
- One natural sub-module: pipe_sat_counter (CNT_W, inc, clear-by-rst). It is reusable for other perf counters.

Test Plan:
- Reset, then stream with out_ready=1: in pc=0x8000_0000/0x8000_0004/0x8000_0008 on consecutive cycles -> same pcs on out one cycle later each; in_ready stays 1; occupancy never exceeds 1.
- Back-pressure: fill with pc A=0x100, B=0x104, out_ready=0 -> occupancy=2, in_ready=0, out_pc=0x100. Hold 5 cycles -> stall_cnt=5. Release -> 0x100 then 0x104 in order, no loss.
- Flush with 2 held entries plus in_valid=1 (pc 0x200) -> next cycle out_valid=0, occupancy=0, out_pc=0, out_instr=0 (ZERO_BUBBLE=1). pc 0x200 never appears. stall_cnt is retained.
- Reset mid-operation with occupancy=2 and stall_cnt=7 -> next cycle all outputs 0, in_ready=1, stall_cnt=0.
- Saturation with CNT_W=4: hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15 and stays 15.
- Random in_valid/out_ready for 10k cycles, with scoreboard and the S-implies-M assertion -> exact in-order delivery, no duplicates; also run ZERO_BUBBLE=0, where outputs hold the last value while out_valid=0.
